// File: rtl/elm_mult_pkg.sv
// ----------------------------------------------------------------------------
// elm_mult_pkg
// Shared definitions for the ELM hidden-layer shift-and-add multiplier.
//   - default operand widths (multiplicand N, multiplier M)
//   - controller state encoding and the enum built on it
//   - helper that sizes the iteration counter
// ----------------------------------------------------------------------------
package elm_mult_pkg;

   localparam int DEFAULT_N = 16;
   localparam int DEFAULT_M = 16;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_ITER = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   typedef enum logic [1:0] {
      IDLE = ST_IDLE,
      ITER = ST_ITER,
      DONE = ST_DONE
   } state_e;

   // The counter must be able to hold every value 0..M without wrapping.
   function automatic int cnt_width(input int m);
      return (m < 1) ? 1 : $clog2(m + 1);
   endfunction

endpackage

// File: rtl/add_sel_mux.sv
// ----------------------------------------------------------------------------
// add_sel_mux
// W-bit 2:1 sum-select mux for one shift-and-add iteration.
//   sum_in  : {0,A}+{0,B}, the adder result including its carry bit
//   pass_in : {0,A}, the accumulator with no addition
//   sel     : current multiplier LSB Q[0]; 1 selects sum_in
//   y       : selected partial sum
// ----------------------------------------------------------------------------
module add_sel_mux #(
   parameter int W = 17
) (
   input  logic [W-1:0] sum_in,
   input  logic [W-1:0] pass_in,
   input  logic         sel,
   output logic [W-1:0] y
);

   assign y = sel ? sum_in : pass_in;

endmodule

// File: rtl/shift_add_mult_ctrl.sv
// ----------------------------------------------------------------------------
// shift_add_mult_ctrl
// Sequential unsigned shift-and-add multiplier: one multiplier bit per clock,
// a single shared N-bit adder, start/valid handshake.
//   clk, rst_n   : rising-edge clock, asynchronous active-low reset
//   start        : request, accepted only while ready is high
//   multiplicand : operand B (N bits), sampled on the accept edge
//   multiplier   : operand Q (M bits), sampled on the accept edge
//   ready        : high in IDLE and DONE
//   busy         : high while iterating
//   valid        : one-cycle pulse in DONE
//   product      : registered N+M-bit result, held until the next result
// ----------------------------------------------------------------------------
module shift_add_mult_ctrl
   import elm_mult_pkg::*;
#(
   parameter int N = DEFAULT_N,
   parameter int M = DEFAULT_M
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [N-1:0]     multiplicand,
   input  logic [M-1:0]     multiplier,
   output logic             ready,
   output logic             busy,
   output logic             valid,
   output logic [N+M-1:0]   product
);

   localparam int CW = cnt_width(M);

   state_e           state_q, state_d;
   logic [N-1:0]     a_q, a_d;
   logic [N-1:0]     b_q, b_d;
   logic [M-1:0]     q_q, q_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [N+M-1:0]   product_q, product_d;

   logic [N:0]       add_full;
   logic [N:0]       sum;
   logic             accept;
   logic             last_iter;

   // The one shared adder; its carry lands in bit N and is shifted back into A.
   assign add_full = {1'b0, a_q} + {1'b0, b_q};

   add_sel_mux #(
      .W (N + 1)
   ) u_add_sel_mux (
      .sum_in  (add_full),
      .pass_in ({1'b0, a_q}),
      .sel     (q_q[0]),
      .y       (sum)
   );

   assign accept    = start && ((state_q == IDLE) || (state_q == DONE));
   assign last_iter = (cnt_q == CW'(M - 1));

   // Next-state and datapath update. A start seen in DONE reloads exactly as
   // from IDLE so back-to-back runs lose no cycle.
   always_comb begin
      state_d   = state_q;
      a_d       = a_q;
      b_d       = b_q;
      q_d       = q_q;
      cnt_d     = cnt_q;
      product_d = product_q;

      case (state_q)
         ITER: begin
            a_d   = sum[N:1];
            q_d   = {sum[0], q_q[M-1:1]};
            cnt_d = cnt_q + CW'(1);
            if (last_iter) begin
               product_d = {sum[N:1], sum[0], q_q[M-1:1]};
               state_d   = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if (accept) begin
         a_d     = '0;
         b_d     = multiplicand;
         q_d     = multiplier;
         cnt_d   = '0;
         state_d = ITER;
      end
   end

   // State and datapath registers; reset aborts any run in progress.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         a_q       <= '0;
         b_q       <= '0;
         q_q       <= '0;
         cnt_q     <= '0;
         product_q <= '0;
      end else begin
         state_q   <= state_d;
         a_q       <= a_d;
         b_q       <= b_d;
         q_q       <= q_d;
         cnt_q     <= cnt_d;
         product_q <= product_d;
      end
   end

   assign ready   = (state_q == IDLE) || (state_q == DONE);
   assign busy    = (state_q == ITER);
   assign valid   = (state_q == DONE);
   assign product = product_q;

endmodule
